// File: rtl/idli_pkg.sv
// Shared idli types and constants.
//   uart_byte_t      : one UART payload byte
//   uart_tx_state_t  : TX serialiser states
//   uart_rx_state_t  : RX deserialiser states
//   UART_ERR_*       : bit positions inside o_uart_err
package idli_pkg;

  localparam int unsigned UART_NIBBLE_W = 4;
  localparam int unsigned UART_BYTE_W   = 8;
  localparam int unsigned UART_ERR_W    = 4;

  localparam int unsigned UART_ERR_TX_OVERFLOW = 0;
  localparam int unsigned UART_ERR_RX_OVERFLOW = 1;
  localparam int unsigned UART_ERR_RX_FRAME    = 2;
  localparam int unsigned UART_ERR_RX_UNDERFLOW = 3;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

  typedef enum logic [1:0] {
    UART_TX_IDLE  = 2'd0,
    UART_TX_START = 2'd1,
    UART_TX_DATA  = 2'd2,
    UART_TX_STOP  = 2'd3
  } uart_tx_state_t;

  typedef enum logic [1:0] {
    UART_RX_IDLE  = 2'd0,
    UART_RX_START = 2'd1,
    UART_RX_DATA  = 2'd2,
    UART_RX_STOP  = 2'd3
  } uart_rx_state_t;

endpackage

// File: rtl/idli_uart_fifo_m.sv
// Synchronous FIFO used for the UART TX and RX byte buffers.
//   i_uart_gck, i_ex_rst_n : clock, async active-low reset
//   push, push_data        : write request (accepted when not full, or full with a pop)
//   pop                    : read request (ignored when empty)
//   head                   : current head entry (combinational)
//   full, empty            : registered occupancy flags
module idli_uart_fifo_m #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_uart_gck,
  input  logic             i_ex_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  // A pop frees the slot first, so a full FIFO still takes a simultaneous push.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_q[rd_ptr_q];

  // Next occupancy.
  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointers and flags; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge i_uart_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      full    <= (count_d == CW'(DEPTH));
      empty   <= (count_d == CW'(0));
    end
  end

  // Storage.
  always_ff @(posedge i_uart_gck) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/idli_uart_m.sv
// UART endpoint facing the EX nibble interface: nibble pairs -> TX FIFO -> 8N1
// line, and 8N1 line -> RX FIFO -> nibbles (low first). Errors are sticky.
//   i_uart_gck, i_ex_rst_n          : clock, async active-low reset
//   i_uart_tx_data, i_uart_tx_vld   : TX nibble from EX (always accepted)
//   o_uart_rx_data, i_uart_rx_acp   : RX nibble to EX (combinational), consume
//   i_uart_rx, o_uart_tx            : serial lines
//   o_uart_tx_full, o_uart_rx_empty : FIFO status
//   o_uart_err, i_uart_err_clr      : {rx_underflow, rx_frame, rx_overflow, tx_overflow}
module idli_uart_m
  import idli_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                     i_uart_gck,
  input  logic                     i_ex_rst_n,
  input  logic [UART_NIBBLE_W-1:0] i_uart_tx_data,
  input  logic                     i_uart_tx_vld,
  output logic [UART_NIBBLE_W-1:0] o_uart_rx_data,
  input  logic                     i_uart_rx_acp,
  input  logic                     i_uart_rx,
  output logic                     o_uart_tx,
  output logic                     o_uart_tx_full,
  output logic                     o_uart_rx_empty,
  output logic [UART_ERR_W-1:0]    o_uart_err,
  input  logic                     i_uart_err_clr
);

  localparam int unsigned DIV_W = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);

  // ---------------------------------------------------------------- TX side
  logic                     tx_hi_q;
  logic [UART_NIBBLE_W-1:0] tx_lo_q;
  logic                     tx_push_q;
  uart_byte_t               tx_push_byte_q;
  uart_byte_t               tx_head;
  logic                     tx_empty;
  logic                     tx_pop_c;

  uart_tx_state_t tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  uart_byte_t       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;
  logic             tx_bit_end;

  // Nibble pairing; the completed byte is pushed one cycle later.
  always_ff @(posedge i_uart_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      tx_hi_q        <= 1'b0;
      tx_lo_q        <= '0;
      tx_push_q      <= 1'b0;
      tx_push_byte_q <= '0;
    end else begin
      tx_push_q <= i_uart_tx_vld && tx_hi_q;
      if (i_uart_tx_vld) begin
        tx_hi_q <= !tx_hi_q;
        if (tx_hi_q) tx_push_byte_q <= {i_uart_tx_data, tx_lo_q};
        else         tx_lo_q        <= i_uart_tx_data;
      end
    end
  end

  idli_uart_fifo_m #(.WIDTH(UART_BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_uart_gck (i_uart_gck),
    .i_ex_rst_n (i_ex_rst_n),
    .push       (tx_push_q),
    .push_data  (tx_push_byte_q),
    .pop        (tx_pop_c),
    .head       (tx_head),
    .full       (o_uart_tx_full),
    .empty      (tx_empty)
  );

  assign tx_bit_end = (tx_cnt_q == DIV_LAST);

  // TX state register.
  always_ff @(posedge i_uart_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      tx_state_q <= UART_TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // TX next state; the line value is registered alongside the state change.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q + DIV_W'(1);
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_pop_c   = 1'b0;
    unique case (tx_state_q)
      UART_TX_IDLE: begin
        tx_line_d = 1'b1;
        tx_cnt_d  = '0;
        if (!tx_empty) begin
          tx_pop_c   = 1'b1;
          tx_shift_d = tx_head;
          tx_line_d  = 1'b0;
          tx_state_d = UART_TX_START;
        end
      end
      UART_TX_START: begin
        if (tx_bit_end) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_line_d  = tx_shift_q[0];
          tx_state_d = UART_TX_DATA;
        end
      end
      UART_TX_DATA: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (tx_bit_q == 3'd7) begin
            tx_line_d  = 1'b1;
            tx_state_d = UART_TX_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_line_d  = tx_shift_q[1];
          end
        end
      end
      UART_TX_STOP: begin
        if (tx_bit_end) begin
          tx_cnt_d = '0;
          if (!tx_empty) begin
            tx_pop_c   = 1'b1;
            tx_shift_d = tx_head;
            tx_line_d  = 1'b0;
            tx_state_d = UART_TX_START;
          end else begin
            tx_line_d  = 1'b1;
            tx_state_d = UART_TX_IDLE;
          end
        end
      end
      default: tx_state_d = UART_TX_IDLE;
    endcase
  end

  assign o_uart_tx = tx_line_q;

  // ---------------------------------------------------------------- RX side
  logic [1:0]       rx_sync_q;
  logic             rx_s;
  uart_rx_state_t   rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  uart_byte_t       rx_shift_q, rx_shift_d;
  logic             rx_push_c;
  logic             rx_frame_c;
  logic             rx_pop_c;
  logic             rx_full;
  uart_byte_t       rx_head;
  logic             rx_hi_q;

  assign rx_s = rx_sync_q[1];

  // Line synchroniser and RX state register.
  always_ff @(posedge i_uart_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      rx_sync_q  <= 2'b11;
      rx_state_q <= UART_RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], i_uart_rx};
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state: start checked mid-bit, then one sample per bit period.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + DIV_W'(1);
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push_c  = 1'b0;
    rx_frame_c = 1'b0;
    unique case (rx_state_q)
      UART_RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s) rx_state_d = UART_RX_START;
      end
      UART_RX_START: begin
        if (rx_cnt_q == DIV_HALF) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_s ? UART_RX_IDLE : UART_RX_DATA;
        end
      end
      UART_RX_DATA: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          rx_bit_d   = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_d = UART_RX_STOP;
        end
      end
      UART_RX_STOP: begin
        if (rx_cnt_q == DIV_LAST) begin
          rx_cnt_d   = '0;
          rx_push_c  = rx_s;
          rx_frame_c = !rx_s;
          rx_state_d = UART_RX_IDLE;
        end
      end
      default: rx_state_d = UART_RX_IDLE;
    endcase
  end

  idli_uart_fifo_m #(.WIDTH(UART_BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_uart_gck (i_uart_gck),
    .i_ex_rst_n (i_ex_rst_n),
    .push       (rx_push_c),
    .push_data  (rx_shift_q),
    .pop        (rx_pop_c),
    .head       (rx_head),
    .full       (rx_full),
    .empty      (o_uart_rx_empty)
  );

  // Nibble drain: second acp of a byte pops it.
  assign rx_pop_c = i_uart_rx_acp && !o_uart_rx_empty && rx_hi_q;

  always_ff @(posedge i_uart_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n) begin
      rx_hi_q <= 1'b0;
    end else if (i_uart_rx_acp && !o_uart_rx_empty) begin
      rx_hi_q <= !rx_hi_q;
    end
  end

  assign o_uart_rx_data = o_uart_rx_empty ? '0
                        : (rx_hi_q ? rx_head[7:4] : rx_head[3:0]);

  // ------------------------------------------------------------ error flags
  logic [UART_ERR_W-1:0] err_q;
  logic [UART_ERR_W-1:0] err_set_c;

  always_comb begin
    err_set_c = '0;
    err_set_c[UART_ERR_TX_OVERFLOW]  = tx_push_q && o_uart_tx_full && !tx_pop_c;
    err_set_c[UART_ERR_RX_OVERFLOW]  = rx_push_c && rx_full && !rx_pop_c;
    err_set_c[UART_ERR_RX_FRAME]     = rx_frame_c;
    err_set_c[UART_ERR_RX_UNDERFLOW] = i_uart_rx_acp && o_uart_rx_empty;
  end

  // Clear wins over a same-cycle set.
  always_ff @(posedge i_uart_gck or negedge i_ex_rst_n) begin
    if (!i_ex_rst_n)         err_q <= '0;
    else if (i_uart_err_clr) err_q <= '0;
    else                     err_q <= err_q | err_set_c;
  end

  assign o_uart_err = err_q;

endmodule

// File: tb/tb_idli_uart_m.sv
// Self-checking bench for idli_uart_m with a queue-based reference model.
module tb_idli_uart_m;

  localparam int unsigned CLK_DIV    = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FRAME      = 10 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] tx_data = '0;
  logic       tx_vld = 1'b0;
  logic [3:0] rx_data;
  logic       rx_acp = 1'b0;
  logic       rx_line = 1'b1;
  logic       tx;
  logic       tx_full;
  logic       rx_empty;
  logic [3:0] err;
  logic       err_clr = 1'b0;

  always #5 clk = ~clk;

  idli_uart_m #(.CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_uart_gck      (clk),
    .i_ex_rst_n      (rst_n),
    .i_uart_tx_data  (tx_data),
    .i_uart_tx_vld   (tx_vld),
    .o_uart_rx_data  (rx_data),
    .i_uart_rx_acp   (rx_acp),
    .i_uart_rx       (rx_line),
    .o_uart_tx       (tx),
    .o_uart_tx_full  (tx_full),
    .o_uart_rx_empty (rx_empty),
    .o_uart_err      (err),
    .i_uart_err_clr  (err_clr)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples each bit at its centre and logs byte + start cycle.
  logic [7:0]  mon_byte_q[$];
  int unsigned mon_start_q[$];
  bit          mon_en = 1'b1;
  int unsigned mon_s;
  logic [7:0]  mon_b;
  logic        mon_stop;

  initial begin : tx_mon
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        mon_s = cyc;
        repeat (CLK_DIV / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CLK_DIV) @(negedge clk);
          mon_b[k] = tx;
        end
        repeat (CLK_DIV) @(negedge clk);
        mon_stop = tx;
        if (mon_en) begin
          check_eq("tx_stop_bit", 32'(mon_stop), 1);
          mon_byte_q.push_back(mon_b);
          mon_start_q.push_back(mon_s);
        end
        repeat (CLK_DIV / 2 - 1) @(negedge clk);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    tx_vld = 1'b1; tx_data = b[3:0];
    @(negedge clk);
    tx_data = b[7:4];
    @(negedge clk);
    tx_vld = 1'b0; tx_data = '0;
  endtask

  // Called at the first sampling point of the start bit; checks every bit's edges.
  task automatic check_frame(input logic [7:0] b);
    logic exp;
    for (int k = 0; k < 10; k++) begin
      exp = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
      check_eq($sformatf("tx_bit%0d_first", k), 32'(tx), 32'(exp));
      repeat (CLK_DIV - 1) @(negedge clk);
      check_eq($sformatf("tx_bit%0d_last", k), 32'(tx), 32'(exp));
      @(negedge clk);
    end
  endtask

  task automatic drive_rx(input logic [7:0] b, input logic stop_bit);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int k = 0; k < 10; k++) begin
      rx_line = bits[k];
      repeat (CLK_DIV) @(negedge clk);
    end
    rx_line = 1'b1;
  endtask

  task automatic acp_pulse();
    rx_acp = 1'b1;
    @(negedge clk);
    rx_acp = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check_eq("err_cleared", 32'(err), 0);
  endtask

  logic [7:0]  tx_bytes [6];
  logic [7:0]  rx_model_q[$];
  logic [7:0]  b;
  logic        rx_ovf_exp;
  int unsigned n1;
  int unsigned zeros;

  initial begin
    // Reset values.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_tx", 32'(tx), 1);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_tx_full", 32'(tx_full), 0);
    check_eq("rst_rx_empty", 32'(rx_empty), 1);
    check_eq("rst_rx_data", 32'(rx_data), 0);

    // Single frame 0xA5 with exact latency and bit timing.
    send_byte(8'hA5);
    check_eq("tx_lat_n", 32'(tx), 1);
    @(negedge clk);
    check_eq("tx_lat_n1", 32'(tx), 1);
    @(negedge clk);
    check_frame(8'hA5);
    check_eq("tx_idle_after", 32'(tx), 1);
    check_eq("tx_err_none", 32'(err), 0);
    mon_byte_q.delete();
    mon_start_q.delete();

    // Six random bytes back-to-back: one goes straight to the line, DEPTH buffer, rest dropped.
    foreach (tx_bytes[i]) tx_bytes[i] = 8'($urandom);
    tx_vld = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tx_data = tx_bytes[i][3:0];
      @(negedge clk);
      tx_data = tx_bytes[i][7:4];
      @(negedge clk);
      if (i == 0) n1 = cyc;
    end
    tx_vld = 1'b0;
    tx_data = '0;
    @(negedge clk);
    check_eq("tx_ovf_err", 32'(err), 32'h1);
    check_eq("tx_full_set", 32'(tx_full), 1);
    repeat (6 * FRAME) @(negedge clk);
    check_eq("tx_frames", mon_byte_q.size(), 1 + FIFO_DEPTH);
    for (int i = 0; i < mon_byte_q.size() && i < 1 + FIFO_DEPTH; i++) begin
      check_eq($sformatf("tx_byte%0d", i), 32'(mon_byte_q[i]), 32'(tx_bytes[i]));
      if (i == 0) check_eq("tx_first_start", mon_start_q[0], n1 + 2);
      else check_eq($sformatf("tx_gap%0d", i), mon_start_q[i] - mon_start_q[i-1], FRAME);
    end
    check_eq("tx_full_drained", 32'(tx_full), 0);
    clear_err();
    mon_byte_q.delete();
    mon_start_q.delete();

    // RX byte 0x3C drained low nibble first.
    drive_rx(8'h3C, 1'b1);
    @(negedge clk);
    check_eq("rx_empty_fell", 32'(rx_empty), 0);
    check_eq("rx_lo_nib", 32'(rx_data), 32'hC);
    acp_pulse();
    check_eq("rx_hi_nib", 32'(rx_data), 32'h3);
    acp_pulse();
    check_eq("rx_empty_again", 32'(rx_empty), 1);
    check_eq("rx_data_empty", 32'(rx_data), 0);
    check_eq("rx_err_none", 32'(err), 0);

    // Random RX burst one past capacity, drained with random acp gaps.
    rx_ovf_exp = 1'b0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      b = 8'($urandom);
      drive_rx(b, 1'b1);
      if (rx_model_q.size() < FIFO_DEPTH) rx_model_q.push_back(b);
      else rx_ovf_exp = 1'b1;
    end
    repeat (2) @(negedge clk);
    check_eq("rx_ovf_err", 32'(err), rx_ovf_exp ? 32'h2 : 32'h0);
    while (rx_model_q.size() > 0) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_eq("rx_burst_lo", 32'(rx_data), 32'(rx_model_q[0][3:0]));
      acp_pulse();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_eq("rx_burst_hi", 32'(rx_data), 32'(rx_model_q[0][7:4]));
      acp_pulse();
      void'(rx_model_q.pop_front());
    end
    check_eq("rx_burst_empty", 32'(rx_empty), 1);
    clear_err();

    // Short low glitch on an idle line.
    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    rx_line = 1'b1;
    repeat (3 * CLK_DIV) @(negedge clk);
    check_eq("glitch_empty", 32'(rx_empty), 1);
    check_eq("glitch_err", 32'(err), 0);

    // Frame with a low stop bit.
    drive_rx(8'($urandom), 1'b0);
    repeat (3 * CLK_DIV) @(negedge clk);
    check_eq("frame_err", 32'(err), 32'h4);
    check_eq("frame_no_byte", 32'(rx_empty), 1);
    clear_err();

    // Underflow, then a byte still arrives low nibble first.
    check_eq("unf_data", 32'(rx_data), 0);
    acp_pulse();
    check_eq("unf_err", 32'(err), 32'h8);
    check_eq("unf_empty", 32'(rx_empty), 1);
    b = 8'($urandom);
    drive_rx(b, 1'b1);
    @(negedge clk);
    check_eq("post_unf_lo", 32'(rx_data), 32'(b[3:0]));

    // Reset mid-frame with TX full, RX holding a byte, an error set, tx_hi pending.
    mon_en = 1'b0;
    tx_vld = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom);
      tx_data = b[3:0];
      @(negedge clk);
      tx_data = b[7:4];
      @(negedge clk);
    end
    tx_data = 4'h7;
    @(negedge clk);
    tx_vld = 1'b0;
    tx_data = '0;
    check_eq("pre_rst_tx_start", 32'(tx), 0);
    check_eq("pre_rst_full", 32'(tx_full), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_tx", 32'(tx), 1);
    check_eq("mid_rst_err", 32'(err), 0);
    check_eq("mid_rst_full", 32'(tx_full), 0);
    check_eq("mid_rst_empty", 32'(rx_empty), 1);
    check_eq("mid_rst_data", 32'(rx_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    zeros = 0;
    repeat (2 * FRAME) begin
      @(negedge clk);
      if (tx !== 1'b1) zeros++;
    end
    check_eq("post_rst_line_idle", zeros, 0);

    // Fresh byte after reset pairs from the low nibble.
    b = 8'($urandom);
    send_byte(b);
    repeat (2) @(negedge clk);
    check_frame(b);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
